// File: rtl/spi_cmd_pkg.sv
// Command codes, frame-length decode and FSM encoding shared by the SPI initiator and subnode.
package spi_cmd_pkg;

    localparam logic [4:0] WR_REG0    = 5'b00000;
    localparam logic [4:0] WR_REG1    = 5'b00001;
    localparam logic [4:0] WR_REG2    = 5'b00010;
    localparam logic [4:0] WR_OP_MODE = 5'b00011;
    localparam logic [4:0] RD_REG0    = 5'b10000;
    localparam logic [4:0] RD_REG1    = 5'b10001;
    localparam logic [4:0] RD_REG2    = 5'b10010;
    localparam logic [4:0] RD_OP_MODE = 5'b10011;
    localparam logic [4:0] RD_S_0     = 5'b10100;
    localparam logic [4:0] RD_S_1     = 5'b10101;
    localparam logic [4:0] RD_S_2     = 5'b10110;
    localparam logic [4:0] RD_S_3     = 5'b10111;
    localparam logic [4:0] RD_S_4     = 5'b11000;

    localparam int unsigned MAX_DATA = 128;
    localparam int unsigned MAX_BITS = 133;
    localparam logic [7:0]  CMD_BITS = 8'd5;

    typedef enum logic [2:0] {
        StIdle,
        StErr,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StGap
    } state_e;

    // Data-bit count for a command; 0 marks an unsupported code.
    function automatic logic [7:0] cmd_len(input logic [4:0] cmd);
        logic [7:0] len;
        case (cmd)
            WR_REG0, WR_REG1, WR_REG2, RD_REG0, RD_REG1, RD_REG2: len = 8'd128;
            WR_OP_MODE, RD_OP_MODE:                               len = 8'd3;
            RD_S_0, RD_S_1, RD_S_2, RD_S_3, RD_S_4:               len = 8'd64;
            default:                                              len = 8'd0;
        endcase
        return len;
    endfunction

    function automatic logic cmd_is_read(input logic [4:0] cmd);
        return cmd[4];
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Parallel request/response port of the SPI initiator.
interface spi_controller_if;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd;
    logic [127:0] wr_data;
    logic [127:0] rd_data;
    logic         done;
    logic         cmd_err;
    logic         busy;

    modport master (
        output cmd_valid, cmd, wr_data,
        input  cmd_ready, rd_data, done, cmd_err, busy
    );

    modport slave (
        input  cmd_valid, cmd, wr_data,
        output cmd_ready, rd_data, done, cmd_err, busy
    );

endinterface

// File: rtl/spi_phase_timer.sv
// Per-phase down-counter: reloads on every phase boundary and ticks in the last cycle of a phase.
module spi_phase_timer #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned EXTRA       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic long_phase,
    output logic tick
);

    localparam int unsigned Width = $clog2(HALF_PERIOD + EXTRA);
    localparam logic [Width-1:0] BaseLoad = Width'(HALF_PERIOD - 1);
    localparam logic [Width-1:0] LongLoad = Width'(HALF_PERIOD + EXTRA - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == '0);

    // long_phase selects the length of the phase that starts after this tick.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = long_phase ? LongLoad : BaseLoad;
        end else begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= BaseLoad;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator issuing spi_subnode command frames, one per csb-low window.
// Define SPI_CTRL_MISO_SYNC_EN to pass miso through a 2-flop synchroniser (HALF_PERIOD >= 6).
module spi_controller
    import spi_cmd_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic            clk,
    input  logic            rst,
    spi_controller_if.slave req,
    output logic            sck,
    output logic            csb,
    output logic            mosi,
    input  logic            miso
);

`ifdef SPI_CTRL_MISO_SYNC_EN
    localparam int unsigned Extra = 2;
`else
    localparam int unsigned Extra = 0;
`endif

    state_e                state_q, state_d;
    logic [7:0]            bit_q, bit_d;
    logic [7:0]            last_q, last_d;
    logic [MAX_BITS-1:0]   tx_q, tx_d;
    logic [MAX_DATA-1:0]   rx_q, rx_d;
    logic [MAX_DATA-1:0]   rd_q, rd_d;
    logic [MAX_DATA-1:0]   payload;
    logic                  is_read_q, is_read_d;
    logic                  done_q, done_d;
    logic [7:0]            len;
    logic                  tick, run, in_frame, long_phase;
    logic                  cap_strobe, cap_en, cap_bit;

    assign len      = cmd_len(req.cmd);
    assign run      = state_q inside {StSetup, StLow, StHigh, StHold, StGap};
    assign in_frame = state_q inside {StSetup, StLow, StHigh, StHold};

    spi_phase_timer #(
        .HALF_PERIOD(HALF_PERIOD),
        .EXTRA      (Extra)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .long_phase(long_phase),
        .tick      (tick)
    );

`ifdef SPI_CTRL_MISO_SYNC_EN
    logic [1:0] miso_sync_q;
    logic [1:0] cap_pipe_q;

    // Capture strobe is delayed to line up with miso leaving the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_sync_q <= '0;
            cap_pipe_q  <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso};
            cap_pipe_q  <= {cap_pipe_q[0], cap_strobe};
        end
    end

    assign cap_en  = cap_pipe_q[1];
    assign cap_bit = miso_sync_q[1];
`else
    assign cap_en  = cap_strobe;
    assign cap_bit = miso;
`endif

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        last_d     = last_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_d       = rd_q;
        is_read_d  = is_read_q;
        done_d     = 1'b0;
        cap_strobe = 1'b0;
        long_phase = 1'b0;
        payload    = '1;

        if (cap_en) begin
            rx_d = {rx_q[MAX_DATA-2:0], cap_bit};
        end

        unique case (state_q)
            StIdle: begin
                if (req.cmd_valid) begin
                    if (len == 8'd0) begin
                        state_d = StErr;
                    end else begin
                        // Left-align the payload so the frame shifts out MSB-first from the top.
                        if (!cmd_is_read(req.cmd)) begin
                            payload = req.wr_data << (8'd128 - len);
                        end
                        state_d   = StSetup;
                        bit_d     = '0;
                        last_d    = len + CMD_BITS - 8'd1;
                        is_read_d = cmd_is_read(req.cmd);
                        tx_d      = {req.cmd, payload};
                        rx_d      = '0;
                    end
                end
            end
            StErr:   state_d = StIdle;
            StSetup: if (tick) state_d = StLow;
            StLow:   if (tick) state_d = StHigh;
            StHigh: begin
                long_phase = (bit_q == last_q);
                if (tick) begin
                    cap_strobe = is_read_q && (bit_q >= CMD_BITS);
                    if (bit_q == last_q) begin
                        state_d = StHold;
                    end else begin
                        state_d = StLow;
                        bit_d   = bit_q + 8'd1;
                        tx_d    = {tx_q[MAX_BITS-2:0], 1'b0};
                    end
                end
            end
            StHold:  if (tick) state_d = StGap;
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (is_read_q) rd_d = rx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_q     <= '0;
            last_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            is_read_q <= 1'b0;
            done_q    <= 1'b0;
            // A reset that aborts a frame keeps the last completed read; an idle reset clears
            // it, so holding rst for two cycles always yields rd_data == 0.
            if (state_q == StIdle || state_q == StErr) rd_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            is_read_q <= is_read_d;
            done_q    <= done_d;
        end
    end

    assign req.cmd_ready = (state_q == StIdle);
    assign req.busy      = (state_q != StIdle);
    assign req.cmd_err   = (state_q == StErr);
    assign req.done      = done_q;
    assign req.rd_data   = rd_q;
    assign sck           = (state_q == StHigh);
    assign csb           = !in_frame;
    assign mosi          = in_frame && tx_q[MAX_BITS-1];

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller with a behavioural spi_subnode model on the SPI pins.
`timescale 1ns/1ps
module tb_spi_controller;

    localparam int H = 4;

    typedef struct {
        bit           is_err;
        bit           chk_rd;
        logic [127:0] rd;
        int           lat;
        int           rises;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sck, csb, mosi, miso;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    spi_controller_if bus ();

    spi_controller #(.HALF_PERIOD(H)) dut (
        .clk (clk),
        .rst (rst),
        .req (bus.slave),
        .sck (sck),
        .csb (csb),
        .mosi(mosi),
        .miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int tb_len(input logic [4:0] c);
        case (c)
            5'd0, 5'd1, 5'd2, 5'd16, 5'd17, 5'd18:  return 128;
            5'd3, 5'd19:                            return 3;
            5'd20, 5'd21, 5'd22, 5'd23, 5'd24:      return 64;
            default:                                return 0;
        endcase
    endfunction

    function automatic exp_t mk(input bit err, input bit chk, input logic [127:0] rd, input int len);
        exp_t e;
        e.is_err = err;
        e.chk_rd = chk;
        e.rd     = rd;
        e.lat    = err ? 0 : H * (2 * (5 + len) + 3);
        e.rises  = err ? 0 : 5 + len;
        return e;
    endfunction

    exp_t sbq[$];

    // ---------------- spi_subnode model ----------------
    logic [127:0] m_reg [3];
    logic [63:0]  m_s [5];
    logic [2:0]   m_op = 3'd0;
    logic         m_op_ready = 1'b0;
    logic [132:0] m_sh;
    logic [127:0] m_rd;
    logic [4:0]   m_cmd = 5'd0;
    int           m_cnt = 0;

    function automatic logic [127:0] tb_rdval(input logic [4:0] c);
        case (c)
            5'd16:   return m_reg[0];
            5'd17:   return m_reg[1];
            5'd18:   return m_reg[2];
            5'd19:   return {125'd0, m_op};
            5'd20:   return {64'd0, m_s[0]};
            5'd21:   return {64'd0, m_s[1]};
            5'd22:   return {64'd0, m_s[2]};
            5'd23:   return {64'd0, m_s[3]};
            5'd24:   return {64'd0, m_s[4]};
            default: return '0;
        endcase
    endfunction

    initial begin
        logic p_sck, p_csb;
        int   l;
        p_sck = 1'b0;
        p_csb = 1'b1;
        miso  = 1'b0;
        m_sh  = '0;
        m_rd  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (csb) begin
                l = tb_len(m_cmd);
                if (!p_csb && m_cnt == 5 + l && l != 0 && !m_cmd[4]) begin
                    case (m_cmd)
                        5'd0: m_reg[0] = m_sh[127:0];
                        5'd1: m_reg[1] = m_sh[127:0];
                        5'd2: m_reg[2] = m_sh[127:0];
                        5'd3: begin m_op = m_sh[2:0]; m_op_ready = 1'b1; end
                        default: ;
                    endcase
                end
                m_cnt = 0;
                miso  = 1'b0;
            end else if (sck && !p_sck) begin
                m_sh = {m_sh[131:0], mosi};
                if (m_cnt == 4) begin
                    m_cmd = m_sh[4:0];
                    m_rd  = tb_rdval(m_cmd);
                end
                if (m_cnt >= 5 && m_cmd[4]) miso = m_rd[tb_len(m_cmd) - 1 - (m_cnt - 5)];
                m_cnt++;
            end
            p_sck = sck;
            p_csb = csb;
        end
    end

    // ---------------- monitor ----------------
    int acc_cyc = 0, rises = 0, frames = 0, high_run = 0, last_gap = 0;
    bit csb_low = 1'b0;

    initial begin
        logic mp_sck, mp_csb;
        exp_t e;
        mp_sck = 1'b0;
        mp_csb = 1'b1;
        forever begin
            @(negedge clk);
            if (sck && !mp_sck) rises++;
            if (!csb) csb_low = 1'b1;
            if (!csb && mp_csb) begin
                frames++;
                last_gap = high_run;
            end
            if (csb) high_run++;
            else high_run = 0;
            mp_sck = sck;
            mp_csb = csb;
            if (bus.done || bus.cmd_err) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: done=%0b cmd_err=%0b, none expected",
                             bus.done, bus.cmd_err);
                end else begin
                    e = sbq.pop_front();
                    check("event_is_err", 128'(bus.cmd_err), 128'(e.is_err));
                    check("event_latency", 128'(cyc - acc_cyc - 1), 128'(e.lat));
                    check("sck_rises", 128'(rises), 128'(e.rises));
                    if (e.chk_rd) check("rd_data", bus.rd_data, e.rd);
                    if (e.is_err) check("csb_stayed_high", 128'(csb_low), 128'(0));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && !rst) begin
                acc_cyc = cyc;
                rises   = 0;
                csb_low = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [4:0] c, input logic [127:0] d, input bit push, input exp_t e);
        bit ok;
        ok = 1'b0;
        if (push) sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.cmd       = c;
        bus.wr_data   = d;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: cmd %b not accepted within 3000 cycles", c);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL event_timeout: %0d expected events still pending after %0d cycles",
                     sbq.size(), budget);
            sbq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D5 = 128'hC3C3_0F0F_1234_5678_9ABC_DEF0_5555_AAAA;
    localparam logic [127:0] D6 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] D7 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] S2 = {64'h0, 64'hDEAD_BEEF_CAFE_F00D};

    initial begin
        exp_t e0;
        int   f0;
        bit   ok;
        e0 = mk(1'b0, 1'b0, '0, 0);
        m_reg[0] = '0;
        m_reg[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        m_reg[2] = '0;
        for (int i = 0; i < 5; i++) m_s[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
        m_s[2] = 64'hDEAD_BEEF_CAFE_F00D;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 5'd0;
        bus.wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_csb", 128'(csb), 128'(1));
        check("reset_sck", 128'(sck), 128'(0));
        check("reset_mosi", 128'(mosi), 128'(0));
        check("reset_rd_data", bus.rd_data, '0);
        check("reset_done", 128'(bus.done), 128'(0));
        check("reset_cmd_err", 128'(bus.cmd_err), 128'(0));
        check("reset_busy", 128'(bus.busy), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", 128'(bus.cmd_ready), 128'(1));

        // 1: 128-bit register write
        issue(5'b00000, D1, 1'b1, mk(1'b0, 1'b0, '0, 128));
        check("busy_after_accept", 128'(bus.busy), 128'(1));
        wait_idle(3000);
        check("model_reg0", m_reg[0], D1);
        check("rd_data_untouched_by_write", bus.rd_data, '0);

        // 2: op-mode write then read back
        issue(5'b00011, 128'h5, 1'b1, mk(1'b0, 1'b0, '0, 3));
        wait_idle(3000);
        check("model_op_mode", 128'(m_op), 128'h5);
        check("model_operation_ready", 128'(m_op_ready), 128'(1));
        issue(5'b10011, '0, 1'b1, mk(1'b0, 1'b1, 128'h5, 3));
        wait_idle(3000);

        // 3: 64-bit status read, 564-cycle frame
        issue(5'b10110, '0, 1'b1, mk(1'b0, 1'b1, S2, 64));
        wait_idle(3000);

        // 4: unsupported command
        issue(5'b01111, D1, 1'b1, mk(1'b1, 1'b0, '0, 0));
        check("err_cycle_not_ready", 128'(bus.cmd_ready), 128'(0));
        @(posedge clk);
        #1;
        check("ready_after_err", 128'(bus.cmd_ready), 128'(1));
        wait_idle(100);

        // 5: reset in the middle of RD_REG1
        issue(5'b10001, '0, 1'b0, e0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (m_cnt == 40) begin
                ok = 1'b1;
                break;
            end
        end
        check("reached_bit_40", 128'(ok), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_csb", 128'(csb), 128'(1));
        check("abort_sck", 128'(sck), 128'(0));
        check("abort_busy", 128'(bus.busy), 128'(0));
        repeat (50) @(posedge clk);
        #1;
        check("abort_rd_data_kept", bus.rd_data, S2);
        issue(5'b00001, D5, 1'b1, mk(1'b0, 1'b0, '0, 128));
        wait_idle(3000);
        check("model_reg1", m_reg[1], D5);
        issue(5'b10001, '0, 1'b1, mk(1'b0, 1'b1, D5, 128));
        wait_idle(3000);

        // 6a: cmd_valid held through a frame -> one frame
        f0 = frames;
        sbq.push_back(mk(1'b0, 1'b0, '0, 128));
        @(posedge clk);
        #1;
        bus.cmd       = 5'b00010;
        bus.wr_data   = D6;
        bus.cmd_valid = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle(3000);
        check("held_valid_frames", 128'(frames - f0), 128'(1));
        check("model_reg2", m_reg[2], D6);

        // 6b: back-to-back write then read
        f0 = frames;
        sbq.push_back(mk(1'b0, 1'b0, '0, 128));
        sbq.push_back(mk(1'b0, 1'b1, D7, 128));
        @(posedge clk);
        #1;
        bus.cmd       = 5'b00000;
        bus.wr_data   = D7;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd = 5'b10000;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("second_accept", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle(3000);
        check("b2b_frames", 128'(frames - f0), 128'(2));
        check("b2b_csb_gap_ge_h", 128'(last_gap >= H), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
